// File: rtl/itrx_aib_phy_repair_pkg.sv
// Shared types for the AIB PHY repair sequencer: the repair-word layout and
// the sequencer state encoding.
package itrx_aib_phy_repair_pkg;

  localparam int REPAIR_INFO_W = 11;
  localparam int DIR_BIT       = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DEC  = 2'd2,
    FIN  = 2'd3
  } seq_state_e;

  // dir: 1 = TX, 0 = RX
  typedef struct packed {
    logic       dir;
    logic [9:0] addr;
  } repair_info_t;

endpackage

// File: rtl/itrx_aib_phy_repair_dec.sv
// Combinational encoder that turns one repair word into the redun_engage shift
// vector of a single channel.
module itrx_aib_phy_repair_dec
  import itrx_aib_phy_repair_pkg::*;
#(
  parameter  int NADDR = 22,
  localparam int W     = 2 * NADDR + 1
) (
  input  repair_info_t   info_i,
  input  logic           vld_i,
  output logic [W-1:0]   engage_o,
  output logic           addr_err_o
);

  localparam int SP = NADDR;

  int   a;
  logic err;

  always_comb begin
    a          = int'(info_i.addr);
    err        = vld_i && (a >= NADDR);
    engage_o   = '0;
    addr_err_o = err;
    // TX fills downward from the split bit, RX fills upward from just above it.
    if (vld_i && !err) begin
      for (int i = 0; i < W; i++) begin
        if (info_i.dir) engage_o[i] = (i <= SP) && (i >= SP - 1 - a);
        else            engage_o[i] = (i >= SP + 1) && (i <= SP + 1 + a);
      end
    end
  end

endmodule

// File: rtl/itrx_aib_phy_repair_seq.sv
// Repair-info loader: sweeps all channels over a req/ack read port, encodes each
// repair word through one shared encoder and holds the per-channel vectors.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   REQ   | rd_req high for channel idx, waiting for ack or timeout
//   DEC   | write encoded vector for idx, advance or finish
//   FIN   | sweep complete, done held until next start
module itrx_aib_phy_repair_seq
  import itrx_aib_phy_repair_pkg::*;
#(
  parameter  int MAXCH = 24,
  parameter  int NADDR = 22,
  parameter  int TOUT  = 255,
  parameter  int CHW   = (MAXCH > 1) ? $clog2(MAXCH) : 1,
  localparam int W     = 2 * NADDR + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  output logic                          rd_req_o,
  output logic [CHW-1:0]                rd_ch_o,
  input  logic                          rd_ack_i,
  input  logic [REPAIR_INFO_W-1:0]      rd_info_i,
  input  logic                          rd_vld_i,
  output logic [MAXCH-1:0][W-1:0]       redun_engage_o,
  output logic [MAXCH-1:0]              addr_err_o,
  output logic [MAXCH-1:0]              tout_err_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int CW = $clog2(TOUT + 1);

  seq_state_e             state_q, state_d;
  logic [CHW-1:0]         idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  repair_info_t           info_q;
  logic                   vld_q;
  logic [MAXCH-1:0][W-1:0] engage_q;
  logic [MAXCH-1:0]       aerr_q, terr_q;

  logic                   clr, cap_ack, cap_tout, wr;
  logic [W-1:0]           dec_engage;
  logic                   dec_err;

  itrx_aib_phy_repair_dec #(.NADDR(NADDR)) u_dec (
    .info_i     (info_q),
    .vld_i      (vld_q),
    .engage_o   (dec_engage),
    .addr_err_o (dec_err)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    clr      = 1'b0;
    cap_ack  = 1'b0;
    cap_tout = 1'b0;
    wr       = 1'b0;
    case (state_q)
      IDLE, FIN: begin
        if (start_i) begin
          clr     = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        // An ack on the terminal cycle takes priority over the timeout.
        if (rd_ack_i) begin
          cap_ack = 1'b1;
          state_d = DEC;
        end else if (cnt_inc == CW'(TOUT)) begin
          cap_tout = 1'b1;
          state_d  = DEC;
        end
      end
      DEC: begin
        wr    = 1'b1;
        cnt_d = '0;
        if (idx_q == CHW'(MAXCH - 1)) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + CHW'(1);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      info_q   <= '0;
      vld_q    <= 1'b0;
      engage_q <= '0;
      aerr_q   <= '0;
      terr_q   <= '0;
    end else begin
      if (clr) begin
        engage_q <= '0;
        aerr_q   <= '0;
        terr_q   <= '0;
      end
      if (cap_ack) begin
        info_q <= repair_info_t'(rd_info_i);
        vld_q  <= rd_vld_i;
      end
      if (cap_tout) begin
        info_q        <= '0;
        vld_q         <= 1'b0;
        terr_q[idx_q] <= 1'b1;
      end
      if (wr) begin
        engage_q[idx_q] <= dec_engage;
        aerr_q[idx_q]   <= dec_err;
      end
    end
  end

  assign rd_req_o       = (state_q == REQ);
  assign rd_ch_o        = idx_q;
  assign busy_o         = (state_q == REQ) || (state_q == DEC);
  assign done_o         = (state_q == FIN);
  assign redun_engage_o = engage_q;
  assign addr_err_o     = aerr_q;
  assign tout_err_o     = terr_q;

endmodule

// File: tb/tb_itrx_aib_phy_repair_seq.sv
// Scoreboard bench: randomized per-channel repair plans, expectations computed
// from the encoding rules and popped by a monitor as requests and sweeps finish.
module tb_itrx_aib_phy_repair_seq;

  localparam int MAXCH = 24;
  localparam int NADDR = 22;
  localparam int TOUT  = 4;
  localparam int CHW   = 5;
  localparam int W     = 2 * NADDR + 1;
  localparam int SP    = NADDR;
  localparam int NEVER = 99;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start_i = 1'b0;
  logic                    rd_req_o;
  logic [CHW-1:0]          rd_ch_o;
  logic                    rd_ack_i = 1'b0;
  logic [10:0]             rd_info_i = '0;
  logic                    rd_vld_i = 1'b0;
  logic [MAXCH-1:0][W-1:0] redun_engage_o;
  logic [MAXCH-1:0]        addr_err_o;
  logic [MAXCH-1:0]        tout_err_o;
  logic                    busy_o;
  logic                    done_o;

  itrx_aib_phy_repair_seq #(.MAXCH(MAXCH), .NADDR(NADDR), .TOUT(TOUT), .CHW(CHW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .rd_req_o       (rd_req_o),
    .rd_ch_o        (rd_ch_o),
    .rd_ack_i       (rd_ack_i),
    .rd_info_i      (rd_info_i),
    .rd_vld_i       (rd_vld_i),
    .redun_engage_o (redun_engage_o),
    .addr_err_o     (addr_err_o),
    .tout_err_o     (tout_err_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [31:0]    len;
  } req_exp_t;

  typedef struct packed {
    logic [MAXCH-1:0][W-1:0] eng;
    logic [MAXCH-1:0]        aerr;
    logic [MAXCH-1:0]        terr;
    logic [31:0]             lat;
  } sweep_exp_t;

  req_exp_t   req_q[$];
  sweep_exp_t sw_q[$];

  int          pl_dly [MAXCH];
  logic [10:0] pl_info[MAXCH];
  logic        pl_vld [MAXCH];

  int n_cmp = 0;
  int n_err = 0;
  int start_cyc = 0;
  bit mon_en = 1'b1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Reference encoding: a contiguous run of ones as a shifted mask.
  function automatic logic [W-1:0] model_vec(logic [10:0] info, logic vld);
    int a;
    logic [63:0] m;
    a = int'(info[9:0]);
    m = '0;
    if (vld && a < NADDR) begin
      if (info[10]) m = ((64'd1 << (a + 2)) - 64'd1) << (SP - 1 - a);
      else          m = ((64'd1 << (a + 1)) - 64'd1) << (SP + 1);
    end
    return m[W-1:0];
  endfunction

  function automatic logic [10:0] rnd_info();
    logic [10:0] v;
    v[10] = 1'($urandom);
    if ($urandom_range(0, 9) < 7) v[9:0] = 10'($urandom_range(0, NADDR - 1));
    else                          v[9:0] = 10'($urandom_range(NADDR, 1023));
    return v;
  endfunction

  // mode 0: directed vectors, 1: zero-wait random, 2: random wait/timeouts
  task automatic build_plan(int mode);
    for (int c = 0; c < MAXCH; c++) begin
      pl_info[c] = rnd_info();
      pl_vld[c]  = ($urandom_range(0, 4) != 0);
      pl_dly[c]  = 0;
      if (mode == 2) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: pl_dly[c] = 0;
          5, 6:          pl_dly[c] = $urandom_range(1, TOUT - 2);
          7:             pl_dly[c] = TOUT - 1;
          default:       pl_dly[c] = NEVER;
        endcase
      end
    end
    if (mode == 0) begin
      pl_info[0]  = 11'h400; pl_vld[0]  = 1'b1;
      pl_dly[3]   = NEVER;
      pl_info[5]  = 11'h415; pl_vld[5]  = 1'b1;
      pl_info[6]  = 11'h015; pl_vld[6]  = 1'b1;
      pl_info[7]  = 11'h000; pl_vld[7]  = 1'b1;
      pl_info[8]  = 11'h405; pl_vld[8]  = 1'b0;
      pl_info[9]  = 11'h416; pl_vld[9]  = 1'b1;
      pl_info[10] = 11'h3FF; pl_vld[10] = 1'b1;
      pl_info[11] = 11'h416; pl_vld[11] = 1'b0;
      pl_info[12] = 11'h7FF; pl_vld[12] = 1'b0;
      pl_dly[13]  = TOUT - 1;
    end
  endtask

  task automatic push_exp();
    sweep_exp_t s;
    req_exp_t   r;
    bit         timed;
    int         len;
    s = '0;
    for (int c = 0; c < MAXCH; c++) begin
      timed = (pl_dly[c] >= TOUT);
      len   = timed ? TOUT : pl_dly[c] + 1;
      r.ch  = CHW'(c);
      r.len = 32'(len);
      req_q.push_back(r);
      s.lat     = s.lat + 32'(len + 1);
      s.terr[c] = timed;
      s.eng[c]  = timed ? '0 : model_vec(pl_info[c], pl_vld[c]);
      s.aerr[c] = !timed && pl_vld[c] && (int'(pl_info[c][9:0]) >= NADDR);
    end
    sw_q.push_back(s);
  endtask

  task automatic do_start();
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start_i   = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_o) break;
    end
    if (!done_o) begin
      fail_now("done_timeout");
      req_q.delete();
      sw_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_rd_req"}, 64'(rd_req_o), 64'd0);
    chk({tag, "_rd_ch"},  64'(rd_ch_o),  64'd0);
    chk({tag, "_busy"},   64'(busy_o),   64'd0);
    chk({tag, "_done"},   64'(done_o),   64'd0);
    chk({tag, "_eng_any"}, 64'(|redun_engage_o), 64'd0);
    chk({tag, "_aerr"},   64'(addr_err_o), 64'd0);
    chk({tag, "_terr"},   64'(tout_err_o), 64'd0);
  endtask

  // Read-port responder; also drives spurious acks while rd_req is low.
  initial begin
    int wc;
    int c;
    wc = 0;
    forever begin
      @(negedge clk);
      if (rd_req_o) begin
        c = int'(rd_ch_o);
        if (c < MAXCH && wc == pl_dly[c]) begin
          rd_ack_i  = 1'b1;
          rd_info_i = pl_info[c];
          rd_vld_i  = pl_vld[c];
        end else begin
          rd_ack_i  = 1'b0;
          rd_info_i = 11'($urandom);
          rd_vld_i  = 1'($urandom);
        end
        wc++;
      end else begin
        wc        = 0;
        rd_ack_i  = ($urandom_range(0, 2) == 0);
        rd_info_i = 11'($urandom);
        rd_vld_i  = 1'($urandom);
      end
    end
  end

  // Monitor: checks each request (channel, length) and each completed sweep.
  initial begin
    int         rl;
    logic       dp;
    req_exp_t   e;
    sweep_exp_t s;
    rl = 0;
    dp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        rl = 0;
        dp = 1'b0;
      end else begin
        if (rd_req_o) begin
          if (rl == 0) begin
            if (req_q.size() == 0) fail_now("unexpected_req");
            else begin
              e = req_q[0];
              chk("rd_ch", 64'(rd_ch_o), 64'(e.ch));
            end
          end
          rl++;
        end else if (rl > 0) begin
          if (req_q.size() != 0) begin
            e = req_q.pop_front();
            chk($sformatf("req_len_ch%0d", e.ch), 64'(rl), 64'(e.len));
          end
          rl = 0;
        end
        if (done_o && !dp) begin
          if (sw_q.size() == 0) fail_now("unexpected_done");
          else begin
            s = sw_q.pop_front();
            for (int c = 0; c < MAXCH; c++) begin
              chk($sformatf("eng[%0d]", c),  64'(redun_engage_o[c]), 64'(s.eng[c]));
              chk($sformatf("aerr[%0d]", c), 64'(addr_err_o[c]),     64'(s.aerr[c]));
              chk($sformatf("terr[%0d]", c), 64'(tout_err_o[c]),     64'(s.terr[c]));
            end
            chk("done_latency", 64'(cyc - start_cyc), 64'(s.lat));
            chk("busy_at_done", 64'(busy_o), 64'd0);
          end
        end
        dp = done_o;
      end
    end
  end

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    build_plan(0);
    push_exp();
    do_start();
    wait_done();

    // zero-wait sweep with a start pulse while busy
    build_plan(1);
    push_exp();
    do_start();
    repeat (7) @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done();

    for (int k = 0; k < 2; k++) begin
      build_plan(2);
      push_exp();
      do_start();
      wait_done();
    end

    // abort in REQ at channel 10
    mon_en = 1'b0;
    build_plan(1);
    do_start();
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rd_req_o && rd_ch_o == CHW'(10)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("abort_ch10_not_reached");
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_abort");
    mon_en = 1'b1;

    for (int k = 0; k < 3; k++) begin
      build_plan((k == 2) ? 1 : 2);
      push_exp();
      do_start();
      wait_done();
    end

    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    chk("sw_q_empty",  64'(sw_q.size()),  64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/itrx_aib_phy_repair_seq.md
Name: itrx_aib_phy_repair_seq

Overview:
Multi-channel, parametrised repair-info loader and encoder for the AIB PHY.
- After a start pulse, walks channels 0..MAXCH-1 and fetches each channel's 11-bit repair word over a req/ack read port.
- Encodes each word into a per-channel redun_engage shift vector of width 2*NADDR+1 and holds the result in registers.
- Sits between the NVM/fuse reader and the per-channel IO redundancy muxes. Generalises the single-channel, fixed-45-bit combinational encoder.

Parameters:
- MAXCH, 24: number of AIB channels sequenced.
- NADDR, 22: number of valid repair addresses per direction. Engage width W = 2*NADDR+1; split bit SP = NADDR.
- TOUT, 255: maximum cycles to wait for rd_ack per channel; must be >= 1.
- CHW, $clog2(MAXCH) (minimum 1): width of the channel index.

Ports:
- clk, input, 1: block clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle pulse that begins a load sweep.
- rd_req, output, 1: read request. Held high until acknowledged or timed out.
- rd_ch, output, CHW: channel index for the current request.
- rd_ack, input, 1: read data valid; sampled only while rd_req=1.
- rd_info, input, 11: repair word. Bit 10 = direction (1=TX, 0=RX); bits 9:0 = address.
- rd_vld, input, 1: repair-present flag for this channel, sampled with rd_ack.
- redun_engage, output, [MAXCH-1:0][W-1:0]: registered engage vectors.
- addr_err, output, MAXCH: per channel, set when rd_vld=1 and address >= NADDR.
- tout_err, output, MAXCH: per channel, set when that channel's read timed out.
- busy, output, 1: sweep in progress.
- done, output, 1: sweep complete. Sticky until the next accepted start.

Behaviour:
Reset
- All outputs 0; FSM in IDLE; channel index 0; timeout counter 0.
- Reset asserted mid-sweep aborts immediately: outputs return to 0 and rd_req drops asynchronously.

FSM states: IDLE, REQ, DEC, FIN.
- IDLE/FIN + start: clear redun_engage, addr_err, tout_err and done; idx=0; go to REQ.
- start while in REQ or DEC is ignored.
- REQ: rd_req=1, rd_ch=idx, busy=1; timeout counter increments each cycle.
  - rd_ack=1: capture rd_info and rd_vld; go to DEC.
  - Counter reaches TOUT with no ack: capture "no repair"; set tout_err[idx]; go to DEC.
  - ack arriving in the same cycle the counter reaches TOUT: ack wins and no timeout is flagged.
- DEC: rd_req=0; write redun_engage[idx] and addr_err[idx] from the captured data; clear the counter.
  - idx==MAXCH-1: go to FIN.
  - otherwise: idx+1, go to REQ.
- FIN: busy=0, done=1; rd_ch holds its last value.

Latency
- rd_req rises the cycle after start.
- redun_engage[idx] is visible the cycle after DEC.
- With zero-wait ack, a full sweep is 2*MAXCH cycles from the start edge to done.

rd_ack while rd_req=0 is ignored.

Encoding, with a = address:
- rd_vld=0: vector = 0.
- a >= NADDR: vector = 0 and addr_err set. Bits 9:0 are compared at full width, so addresses up to 1023 are caught.
- TX (bit10=1): bits [SP : SP-1-a] = 1, all others 0. That is a+2 ones.
- RX (bit10=0): bits [SP+1+a : SP+1] = 1, all others 0. That is a+1 ones.
- Arithmetic is done in 11-bit unsigned; no wrap.

Decomposition:
- Package itrx_aib_phy_repair_pkg holds:
  - REPAIR_INFO_W=11 and the direction-bit index 10.
  - The FSM state enum (IDLE, REQ, DEC, FIN).
  - A typedef for the repair word with fields dir and addr[9:0].
- Sub-module itrx_aib_phy_repair_dec: combinational encoder for one channel. Parameter NADDR; inputs info and vld; outputs engage[W-1:0] and addr_err. Instantiated once and shared across channels by the sequencer.

Test Plan:
Unless noted, MAXCH=24, NADDR=22, zero-wait ack.
1. TX a=0 on ch0 (rd_info=11'h400, vld=1) -> redun_engage[0] = 45'h0000_0060_0000 and addr_err[0]=0.
2. TX a=21 on ch5 (11'h415) -> 45'h0000_007F_FFFF. RX a=21 on ch6 (11'h015) -> 45'h1FFF_FF80_0000. RX a=0 on ch7 -> 45'h0000_0080_0000.
3. rd_vld=0 with any data, or address 22 (11'h416) or 1023 -> vector = 0; addr_err set only in the vld=1 cases.
4. TOUT=4 and ch3 never acks -> rd_req high for 4 cycles then drops; tout_err[3]=1; redun_engage[3]=0; sweep continues to ch4; done=1.
5. start pulsed while busy, and a spurious rd_ack with rd_req=0 -> no effect on idx or outputs. done asserts exactly 48 cycles after the start edge with zero-wait ack.
6. rst_n asserted while in REQ at ch10 -> all outputs 0 immediately. A new start resweeps from ch0 with correct vectors.
